// File: rtl/rsr_reg.sv
// UART receive shift register: 16x-oversampled start detect, 5-8 data bits LSB-first, optional parity, stop check.
// Character and error pulses registered one clk after the stop-sample tick; no backpressure, fifo_full only flags overrun.
module rsr_reg #(
  parameter int OSR = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stick,
  input  logic       rx_in,
  input  logic [1:0] rlen,
  input  logic       parity_en,
  input  logic       parity_type,
  input  logic       fifo_full,
  output logic [7:0] rdata,
  output logic       wr_en,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun_err
);

  localparam logic [3:0] MID  = 4'(OSR / 2 - 1);
  localparam logic [3:0] LAST = 4'(OSR - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic       rx_m_q, rx_s_q;
  logic       rx_d_q, rx_d_d;
  logic [3:0] tcnt_q, tcnt_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic [7:0] sreg_q, sreg_d;
  logic [1:0] len_q, len_d;
  logic       pen_q, pen_d;
  logic       ptype_q, ptype_d;
  logic       perr_q, perr_d;
  logic [7:0] rdata_q, rdata_d;
  logic       wr_en_q, wr_en_d;
  logic       pe_q, pe_d;
  logic       fe_q, fe_d;
  logic       oe_q, oe_d;

  logic [2:0] last_bit;
  logic [7:0] shifted;
  logic [7:0] data_mask;
  logic       exp_par;

  always_comb begin
    last_bit  = {1'b0, len_q} + 3'd4;
    data_mask = 8'hFF >> (3'd7 - last_bit);
    shifted   = {1'b0, sreg_q[7:1]};
    shifted[last_bit] = rx_s_q;
    exp_par   = ptype_q ? ~^sreg_q : ^sreg_q;
  end

  always_comb begin
    state_d = state_q;
    rx_d_d  = stick ? rx_s_q : rx_d_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    sreg_d  = sreg_q;
    len_d   = len_q;
    pen_d   = pen_q;
    ptype_d = ptype_q;
    perr_d  = perr_q;
    rdata_d = rdata_q;
    wr_en_d = 1'b0;
    pe_d    = 1'b0;
    fe_d    = 1'b0;
    oe_d    = 1'b0;

    case (state_q)
      IDLE: begin
        // Only a 1->0 transition between ticks starts a frame, so a held-low line cannot retrigger.
        if (stick && rx_d_q && !rx_s_q) begin
          state_d = START;
          tcnt_d  = 4'd0;
          len_d   = rlen;
          pen_d   = parity_en;
          ptype_d = parity_type;
        end
      end
      START: begin
        if (stick) begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == MID) begin
            if (!rx_s_q) begin
              state_d = DATA;
              tcnt_d  = 4'd0;
              bcnt_d  = 3'd0;
              sreg_d  = 8'd0;
              perr_d  = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      DATA: begin
        if (stick) begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == LAST) begin
            sreg_d = shifted;
            tcnt_d = 4'd0;
            if (bcnt_q == last_bit) begin
              state_d = pen_q ? PARITY : STOP;
            end else begin
              bcnt_d = bcnt_q + 3'd1;
            end
          end
        end
      end
      PARITY: begin
        if (stick) begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == LAST) begin
            perr_d  = (rx_s_q != exp_par);
            tcnt_d  = 4'd0;
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (stick) begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == LAST) begin
            // Return to IDLE at mid stop bit so a following start edge is not missed.
            state_d = IDLE;
            tcnt_d  = 4'd0;
            rdata_d = sreg_q & data_mask;
            if (!fifo_full) begin
              wr_en_d = 1'b1;
              pe_d    = perr_q;
              fe_d    = ~rx_s_q;
            end else begin
              oe_d    = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rx_m_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      rx_d_q  <= 1'b1;
      tcnt_q  <= 4'd0;
      bcnt_q  <= 3'd0;
      sreg_q  <= 8'd0;
      len_q   <= 2'd0;
      pen_q   <= 1'b0;
      ptype_q <= 1'b0;
      perr_q  <= 1'b0;
      rdata_q <= 8'd0;
      wr_en_q <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rx_m_q  <= rx_in;
      rx_s_q  <= rx_m_q;
      rx_d_q  <= rx_d_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      sreg_q  <= sreg_d;
      len_q   <= len_d;
      pen_q   <= pen_d;
      ptype_q <= ptype_d;
      perr_q  <= perr_d;
      rdata_q <= rdata_d;
      wr_en_q <= wr_en_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      oe_q    <= oe_d;
    end
  end

  assign rdata       = rdata_q;
  assign wr_en       = wr_en_q;
  assign parity_err  = pe_q;
  assign frame_err   = fe_q;
  assign overrun_err = oe_q;

endmodule

// File: tb/tb_rsr_reg.sv
// Bench for rsr_reg: drives whole serial frames on tick boundaries and compares every output pulse against a frame-level model.
module tb_rsr_reg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stick = 1'b0;
  logic       rx_in = 1'b1;
  logic [1:0] rlen = 2'b11;
  logic       parity_en = 1'b0;
  logic       parity_type = 1'b0;
  logic       fifo_full = 1'b0;
  logic [7:0] rdata;
  logic       wr_en, parity_err, frame_err, overrun_err;

  typedef struct packed {
    logic        wr;
    logic        pe;
    logic        fe;
    logic        oe;
    logic [7:0]  d;
    logic [31:0] tick;
  } evt_t;

  evt_t        obs_q[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned tick_idx = 0;

  rsr_reg #(.OSR(16)) dut (
    .clk(clk), .rst_n(rst_n), .stick(stick), .rx_in(rx_in),
    .rlen(rlen), .parity_en(parity_en), .parity_type(parity_type), .fifo_full(fifo_full),
    .rdata(rdata), .wr_en(wr_en), .parity_err(parity_err), .frame_err(frame_err),
    .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  // One stick every 4 clks; tick_idx names the tick sampled at the next rising edge.
  initial begin
    forever begin
      repeat (3) @(posedge clk);
      #1 stick = 1'b1;
      tick_idx++;
      @(posedge clk);
      #1 stick = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (wr_en || parity_err || frame_err || overrun_err)
      obs_q.push_back({wr_en, parity_err, frame_err, overrun_err, rdata, tick_idx});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  task automatic wait_tick;
    do @(posedge clk); while (stick !== 1'b1);
  endtask

  task automatic drive_bit(input logic b);
    wait_tick();
    #1 rx_in = b;
    repeat (15) wait_tick();
  endtask

  task automatic send_frame(input logic [7:0] data, input logic [1:0] len, input logic pen,
                            input logic ptype, input logic par_bit, input logic stp,
                            input logic full, input logic scr, output int unsigned t0);
    int n;
    n = int'(len) + 5;
    rlen = len; parity_en = pen; parity_type = ptype;
    fifo_full = scr ? 1'($urandom) : full;
    wait_tick();
    t0 = tick_idx;
    #1 rx_in = 1'b0;
    repeat (15) wait_tick();
    if (scr) begin
      rlen = 2'($urandom); parity_en = 1'($urandom); parity_type = 1'($urandom);
    end
    for (int i = 0; i < n; i++) drive_bit(data[i]);
    if (pen) drive_bit(par_bit);
    fifo_full = full;
    drive_bit(stp);
    if (!stp) drive_bit(1'b1);
  endtask

  // Frame-level expectation: what the receiver should report for one transmitted character.
  function automatic evt_t model(input logic [7:0] data, input logic [1:0] len, input logic pen,
                                 input logic ptype, input logic par_bit, input logic stp,
                                 input logic full, input int unsigned t0);
    evt_t e;
    int n, ones;
    logic [7:0] d;
    logic want;
    n    = int'(len) + 5;
    d    = data & (8'hFF >> (8 - n));
    ones = $countones(d);
    want = ones[0] ^ ptype;
    e.d    = d;
    e.tick = t0 + 32'd9 + 32'(16 * (n + int'(pen) + 1));
    if (full) begin
      e.wr = 1'b0; e.pe = 1'b0; e.fe = 1'b0; e.oe = 1'b1;
    end else begin
      e.wr = 1'b1; e.pe = pen && (par_bit != want); e.fe = ~stp; e.oe = 1'b0;
    end
    return e;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({rdata, wr_en, parity_err, frame_err, overrun_err} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=000", {rdata, wr_en, parity_err, frame_err, overrun_err});
    end
    rst_n = 1'b1;
    repeat (40) wait_tick();
    obs_q.delete();
  endtask

  task automatic test_8n1;
    int unsigned t0;
    evt_t exp, got;
    send_frame(8'hEB, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, t0);
    exp = model(8'hEB, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, t0);
    got = (obs_q.size() > 0) ? obs_q[0] : '0;
    checks++;
    if (obs_q.size() != 1) begin failures++; $display("FAIL 8n1_count got=%0d want=1", obs_q.size()); end
    checks++;
    if (got !== exp) begin failures++; $display("FAIL 8n1_evt got=%h want=%h", got, exp); end
    checks++;
    if ({got.wr, got.pe, got.fe, got.oe, got.d} !== 12'h8EB) begin
      failures++; $display("FAIL 8n1_const got=%h want=8eb", {got.wr, got.pe, got.fe, got.oe, got.d});
    end
    obs_q.delete();
  endtask

  task automatic test_lengths;
    logic [7:0] din  [3] = '{8'hDA, 8'hF5, 8'hEB};
    logic [7:0] dout [3] = '{8'h1A, 8'h35, 8'h6B};
    int unsigned t0;
    evt_t exp, got;
    for (int i = 0; i < 3; i++) begin
      send_frame(din[i], 2'(i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, t0);
      exp = model(din[i], 2'(i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, t0);
      got = (obs_q.size() > 0) ? obs_q[0] : '0;
      checks++;
      if (obs_q.size() != 1 || got !== exp) begin
        failures++; $display("FAIL len%0d_evt n=%0d got=%h want=%h", i, obs_q.size(), got, exp);
      end
      checks++;
      if (got.d !== dout[i] || got.wr !== 1'b1) begin
        failures++; $display("FAIL len%0d_rdata got=%h want=%h", i, got.d, dout[i]);
      end
      obs_q.delete();
    end
  endtask

  task automatic test_parity;
    int unsigned t0;
    evt_t exp, got;
    for (int i = 0; i < 2; i++) begin
      send_frame(8'hA5, 2'b11, 1'b1, 1'b1, 1'(1 - i), 1'b1, 1'b0, 1'b0, t0);
      exp = model(8'hA5, 2'b11, 1'b1, 1'b1, 1'(1 - i), 1'b1, 1'b0, t0);
      got = (obs_q.size() > 0) ? obs_q[0] : '0;
      checks++;
      if (obs_q.size() != 1 || got !== exp) begin
        failures++; $display("FAIL parity%0d_evt n=%0d got=%h want=%h", i, obs_q.size(), got, exp);
      end
      checks++;
      if (got.wr !== 1'b1 || got.pe !== 1'(i)) begin
        failures++; $display("FAIL parity%0d_flag wr=%b pe=%b want_pe=%0d", i, got.wr, got.pe, i);
      end
      obs_q.delete();
    end
  endtask

  task automatic test_glitch;
    wait_tick();
    #1 rx_in = 1'b0;
    repeat (3) wait_tick();
    #1 rx_in = 1'b1;
    repeat (40) wait_tick();
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL glitch_events got=%0d want=0", obs_q.size()); end
    checks++;
    if (rdata !== 8'hA5) begin failures++; $display("FAIL glitch_rdata_hold got=%h want=a5", rdata); end
    obs_q.delete();
  endtask

  task automatic test_frame_err;
    int unsigned t0;
    evt_t exp, got;
    send_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, t0);
    exp = model(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, t0);
    got = (obs_q.size() > 0) ? obs_q[0] : '0;
    checks++;
    if (obs_q.size() != 1 || got !== exp) begin
      failures++; $display("FAIL frame_err_evt n=%0d got=%h want=%h", obs_q.size(), got, exp);
    end
    obs_q.delete();
  endtask

  task automatic test_break;
    int unsigned t0;
    evt_t exp, got;
    rlen = 2'b11; parity_en = 1'b0; fifo_full = 1'b0;
    wait_tick();
    t0 = tick_idx;
    #1 rx_in = 1'b0;
    repeat (300) wait_tick();
    #1 rx_in = 1'b1;
    repeat (20) wait_tick();
    exp = '{wr: 1'b1, pe: 1'b0, fe: 1'b1, oe: 1'b0, d: 8'h00, tick: t0 + 32'd153};
    got = (obs_q.size() > 0) ? obs_q[0] : '0;
    checks++;
    if (obs_q.size() != 1 || got !== exp) begin
      failures++; $display("FAIL break_evt n=%0d got=%h want=%h", obs_q.size(), got, exp);
    end
    obs_q.delete();
  endtask

  task automatic test_overrun;
    int unsigned t0;
    evt_t exp, got;
    send_frame(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, t0);
    exp = model(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, t0);
    got = (obs_q.size() > 0) ? obs_q[0] : '0;
    checks++;
    if (obs_q.size() != 1 || got !== exp || got.wr !== 1'b0) begin
      failures++; $display("FAIL overrun_evt n=%0d got=%h want=%h", obs_q.size(), got, exp);
    end
    obs_q.delete();
    send_frame(8'h12, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, t0);
    exp = model(8'h12, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, t0);
    got = (obs_q.size() > 0) ? obs_q[0] : '0;
    checks++;
    if (obs_q.size() != 1 || got !== exp) begin
      failures++; $display("FAIL overrun_next_evt n=%0d got=%h want=%h", obs_q.size(), got, exp);
    end
    obs_q.delete();
  endtask

  task automatic test_reset_midframe;
    logic [7:0] d = 8'h5A;
    int unsigned t0;
    evt_t exp, got;
    rlen = 2'b11; parity_en = 1'b0; fifo_full = 1'b0;
    wait_tick();
    #1 rx_in = 1'b0;
    repeat (15) wait_tick();
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    wait_tick();
    #1 rx_in = d[3];
    repeat (6) wait_tick();
    @(negedge clk);
    rst_n = 1'b0;
    rx_in = 1'b1;
    @(negedge clk);
    checks++;
    if ({rdata, wr_en, parity_err, frame_err, overrun_err} !== 12'h000) begin
      failures++;
      $display("FAIL midreset_outputs got=%h want=000", {rdata, wr_en, parity_err, frame_err, overrun_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (200) wait_tick();
    checks++;
    if (obs_q.size() != 0 || rdata !== 8'h00) begin
      failures++; $display("FAIL midreset_discard events=%0d rdata=%h want 0/00", obs_q.size(), rdata);
    end
    obs_q.delete();
    send_frame(8'h81, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, t0);
    exp = model(8'h81, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, t0);
    got = (obs_q.size() > 0) ? obs_q[0] : '0;
    checks++;
    if (obs_q.size() != 1 || got !== exp) begin
      failures++; $display("FAIL midreset_next_evt n=%0d got=%h want=%h", obs_q.size(), got, exp);
    end
    obs_q.delete();
  endtask

  task automatic test_random;
    int unsigned t0;
    evt_t exp, got;
    logic [7:0] data;
    logic [1:0] len;
    logic pen, ptype, par, stp, full;
    for (int i = 0; i < 25; i++) begin
      data  = 8'($urandom);
      len   = 2'($urandom);
      pen   = 1'($urandom);
      ptype = 1'($urandom);
      par   = 1'($urandom);
      stp   = ($urandom_range(0, 9) != 0);
      full  = ($urandom_range(0, 4) == 0);
      send_frame(data, len, pen, ptype, par, stp, full, 1'b1, t0);
      exp = model(data, len, pen, ptype, par, stp, full, t0);
      got = (obs_q.size() > 0) ? obs_q[0] : '0;
      checks++;
      if (obs_q.size() != 1 || got !== exp) begin
        failures++;
        $display("FAIL rand%0d_evt n=%0d got=%h want=%h (d=%h len=%0d pen=%b odd=%b par=%b stop=%b full=%b)",
                 i, obs_q.size(), got, exp, data, len, pen, ptype, par, stp, full);
      end
      obs_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_lengths();
    test_parity();
    test_glitch();
    test_frame_err();
    test_break();
    test_overrun();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rsr_reg.md
# rsr_reg

Receive shift register for the UART IP, the receive-side counterpart of the transmit shift register. It samples the asynchronous serial input with a 16x oversampling tick and detects the start bit. It deserialises 5–8 data bits LSB-first and checks the optional parity and stop bits. Each completed character is written into the RX FIFO with a one-cycle write strobe and per-character error flags.

## Interface
- `OSR`, 16, oversampling ticks per bit; fixed value, mid-bit = `OSR/2`.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset: synchronous, active-low.
- `stick`  in  1  sample tick, one-`clk` pulse at 16x baud rate, from the baud generator.
- `rx_in`  in  1  asynchronous serial line; idle high.
- `rlen`  in  2  data length: 00=5, 01=6, 10=7, 11=8 bits.
- `parity_en`  in  1  1 = parity bit present after data.
- `parity_type`  in  1  0 = even, 1 = odd.
- `fifo_full`  in  1  RX FIFO full.
- `rdata`  out  8  received character, zero-extended above `rlen` bits.
- `wr_en`  out  1  one-`clk` write strobe to the RX FIFO.
- `parity_err`  out  1  one-`clk` pulse with the frame-complete event; received parity ≠ expected.
- `frame_err`  out  1  one-`clk` pulse with the frame-complete event; stop bit sampled 0.
- `overrun_err`  out  1  one-`clk` pulse; the frame completed while `fifo_full`=1.

## Operation
- **Synchroniser:** `rx_in` → 2-flop synchroniser `rx_s`, reset value 1. A delayed copy `rx_d` is used for edge detection.
- **Config latching:** `rlen`, `parity_en` and `parity_type` are latched on start detection. Changes mid-frame have no effect until the next frame.
- **Counters:**
  - Tick counter `tcnt` (4 bits) advances only on `stick`.
  - Bit counter `bcnt` (3 bits).
  - Shift register `sreg` (8 bits) shifts right, with the new bit entering at bit [N-1], N = latched length.
- **State `IDLE`:** on `stick` with `rx_d`=1 and `rx_s`=0 (falling edge) → `START`, `tcnt`=0. A line that is low continuously without a 1→0 edge does not start a frame.
- **State `START`:** on `stick`, `tcnt`++. On the `stick` where `tcnt`==7 (mid start bit):
  - if `rx_s`=0 → `DATA`, `tcnt`=0, `bcnt`=0, `sreg`=0;
  - else false start → `IDLE`, no outputs.
- **State `DATA`:** on the `stick` where `tcnt`==15, sample `rx_s` into `sreg` and set `tcnt`=0. If `bcnt`==N-1, go to `PARITY` (when `parity_en`) or `STOP`; otherwise `bcnt`++.
- **State `PARITY`:** sample at `tcnt`==15 and store `perr` = sampled bit ≠ expected. Expected is `^data` for even and `~^data` for odd. Then → `STOP`.
- **State `STOP`:** sample at `tcnt`==15, then → `IDLE` (mid stop bit, which allows back-to-back frames). The sample completes the frame:
  - `rdata` ← `sreg` with bits ≥ N forced to 0;
  - if `fifo_full`=0: `wr_en`=1 and `parity_err`=`perr`, `frame_err`=~stop;
  - if `fifo_full`=1: `wr_en`=0 and `overrun_err`=1; the character is dropped but `rdata` is still updated.
- **Frame and parity errors** do not suppress the write; the character is written and flagged.
- **Break** (line held low): start, all-zero data, stop = 0 → `rdata`=0x00, `frame_err`=1. No new frame starts until the line returns high and falls again.
- **Reset mid-frame:** next edge → `IDLE`, counters and `sreg` cleared, and the character in progress is discarded.
- **Reset values:** `rdata`=0x00, `wr_en`=0, `parity_err`=0, `frame_err`=0, `overrun_err`=0, state `IDLE`.

## Timing
- Input synchroniser latency: 2 `clk`.
- Sample point is 8 ticks after the detected edge, then every 16 ticks (bit centre ±1 tick).
- `wr_en` and the error pulses are registered: asserted the `clk` after the stop-sample `stick`, for exactly one `clk`. `rdata` is valid in the same cycle and held until the next frame completes.
- Frame length in ticks from the detected edge to the stop sample: 8 + 16·(N + P + 1), where P = 1 if parity enabled, else 0.
- Back-to-back frames: a new start edge is accepted from the `stick` after the return to `IDLE`.
- `fifo_full` is sampled only on the completing `stick`; it is ignored at all other times.

## Test plan
- **8N1:** drive 0xEB (`rlen`=11, parity off) at 16 ticks/bit → exactly one `wr_en` with `rdata`=0xEB; `parity_err`, `frame_err` and `overrun_err` all 0.
- **5/6/7-bit:** drive 0xDA with `rlen`=00 → `rdata`=0x1A. Drive 0xF5 with `rlen`=01 → `rdata`=0x35. Drive 0xEB with `rlen`=10 → `rdata`=0x6B.
- **Parity:**
  - 0xA5, 8 bits, odd parity, correct parity bit 1 → `wr_en`=1, `parity_err`=0;
  - same frame with parity bit 0 → `wr_en`=1, `parity_err`=1.
- **Glitch / framing:**
  - `rx_in` low for 3 ticks only → no `wr_en`, state returns to `IDLE`;
  - 8N1 frame 0x3C with stop bit 0 → `rdata`=0x3C, `wr_en`=1, `frame_err`=1.
- **Overrun:** `fifo_full`=1 during the stop sample of frame 0x55 → `wr_en`=0, `overrun_err`=1. The next frame 0x12 with `fifo_full`=0 is written normally.
- **Reset mid-frame:**
  - `rst_n`=0 for 2 `clk` during data bit 3 → all outputs 0 and no `wr_en` for that frame;
  - the following frame 0x81 is received correctly.
